seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port Start, input, 1, request; sampled only when Busy=0.
REQ-005 SHALL have port ALUControl, input, 4, opcode: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 sll, 7 srl, 8 slt, 9 sltu, 10 mult, 11 multu, 12 div, 13 divu, 14-15 illegal.
REQ-006 SHALL have ports A and B, input, WIDTH each, operands.
REQ-007 SHALL have port Result, output, WIDTH, registered result; equals Lo for mult/div.
REQ-008 SHALL have port Hi, output, WIDTH, upper product or remainder register.
REQ-009 SHALL have port Zero, output, 1, registered flag equal to (Result==0).
REQ-010 SHALL have port Busy, output, 1, high while a multi-cycle operation is in progress.
REQ-011 SHALL have port Done, output, 1, one-cycle pulse marking a valid Result.
REQ-012 SHALL have port Illegal, output, 1, registered and updated on each Done; high when the completed opcode was illegal.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; accepting Start in IDLE latches ALUControl, A and B, and later operand changes have no effect.
REQ-014 SHALL, for opcodes 0-9 and illegal opcodes, update Result, Zero and Illegal and pulse Done at the edge after Start is sampled, so latency is 1 and the FSM stays in IDLE.
REQ-015 SHALL compute add/sub modulo 2^WIDTH with no overflow trap.
REQ-016 SHALL shift A by B[log2(WIDTH)-1:0] for sll/srl, with srl logical.
REQ-017 SHALL compute slt as signed and sltu as unsigned compare, giving a result of 0 or 1.
REQ-018 SHALL, for mult/multu, enter MUL and perform an iterative shift-add, one bit per cycle for WIDTH cycles; Done pulses exactly WIDTH+1 edges after the Start-sampling edge, with {Hi,Result} holding the 2*WIDTH product.
REQ-019 SHALL handle signed mult by magnitude iteration followed by conditional negation of the 2*WIDTH product.
REQ-020 SHALL, for div/divu, enter DIV and perform restoring division over WIDTH cycles with the same latency as mult; Result is the quotient and Hi the remainder.
REQ-021 SHALL, for signed div, truncate toward zero: quotient sign = signA^signB and remainder sign = signA.
REQ-022 SHALL, on divide by zero (signed or unsigned), produce Result all ones and Hi = A, with the same latency and no flag.
REQ-023 SHALL hold Busy=1 in MUL/DIV, fall to 0 in the Done cycle, and keep Busy=0 for 1-cycle ops.
REQ-024 SHALL ignore Start while Busy=1, with no queuing.
REQ-025 SHALL accept Start in the cycle Done is high, allowing back-to-back operations.
REQ-026 SHALL hold Result, Hi, Zero and Illegal until the next Done; Hi changes only on mult/div completion.

Reset
REQ-027 SHALL, when Reset=1 at an edge, including mid-MUL/DIV, force IDLE, Result=0, Hi=0, Zero=1, Busy=0, Done=0, Illegal=0, and abort any in-flight operation without a Done pulse.
REQ-028 SHALL give Reset priority over a simultaneous Start.

Configuration
REQ-029 SHALL provide divide hardware (REQ-020..022) only when macro SEQ_ALU_DIV_EN is defined.
REQ-030 SHALL, without SEQ_ALU_DIV_EN, treat opcodes 12-13 as illegal: Done after 1 cycle, Result=0, Zero=1, Illegal=1, Hi unchanged, and the DIV state absent.

Verification (WIDTH=32)
REQ-031 SHALL cover: add 0x7FFFFFFF+1 -> Result 0x80000000, Zero=0, Done one edge after Start; sub 5-5 -> Result 0, Zero=1.
REQ-032 SHALL cover: mult -3*7 -> Hi 0xFFFFFFFF, Result 0xFFFFFFEB, Busy high throughout, Done exactly 33 edges after the Start edge; multu 0xFFFFFFFF*2 -> Hi 1, Result 0xFFFFFFFE.
REQ-033 SHALL cover (SEQ_ALU_DIV_EN defined): div -7/2 -> Result 0xFFFFFFFD, Hi 0xFFFFFFFF; divu 7/0 -> Result 0xFFFFFFFF, Hi 7.
REQ-034 SHALL cover: add Start pulsed at cycle 5 of a mult -> ignored, a single Done for the mult only; Start asserted on the Done cycle -> the next op is accepted.
REQ-035 SHALL cover: Reset at cycle 10 of a mult -> Busy=0, Result=0, Hi=0, Zero=1 next cycle, no Done pulse; opcode 15 -> Illegal=1, Done after 1 cycle.
REQ-036 SHALL cover (SEQ_ALU_DIV_EN undefined): div 8/2 -> Illegal=1, Result 0, Done after 1 cycle, Hi unchanged from the prior mult.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with 1-cycle logic/compare ops and iterative multiply/divide.
// Divide hardware is built only when SEQ_ALU_DIV_EN is defined; otherwise opcodes 12-13 are illegal.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3,
    OP_NOR  = 4'd4,  OP_XOR  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL   = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MULT = 4'd10, OP_MULTU = 4'd11,
    OP_DIV  = 4'd12, OP_DIVU = 4'd13
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
`ifdef SEQ_ALU_DIV_EN
    DIV,
`endif
    MUL
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, lo_q, mcand_q, result_q, hi_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_q, done_q, zero_q, illegal_q;

  logic             accept, start_mul, start_div, sign_op, alu_ill;
  logic [WIDTH-1:0] a_mag, b_mag, alu_res, step_acc, step_lo, fin_lo, fin_hi;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   div_rs;
  logic             div_ge;
`endif

  assign accept    = Start && (state_q == IDLE);
  assign start_mul = accept && (ALUControl == OP_MULT || ALUControl == OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
  assign start_div = accept && (ALUControl == OP_DIV || ALUControl == OP_DIVU);
  assign sign_op   = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
`else
  assign start_div = 1'b0;
  assign sign_op   = (ALUControl == OP_MULT);
`endif
  assign a_mag = (sign_op && A[WIDTH-1]) ? -A : A;
  assign b_mag = (sign_op && B[WIDTH-1]) ? -B : B;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mul) state_d = MUL;
`ifdef SEQ_ALU_DIV_EN
        else if (start_div) state_d = DIV;
`endif
      end
      default: if (cnt_q == CW'(WIDTH)) state_d = IDLE;
    endcase
  end

  // Single-cycle ops execute one edge after acceptance from the latched operands.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SW-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SW-1:0];
      OP_SLT:  alu_res = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SLTU: alu_res = WIDTH'(a_q < b_q);
      default: alu_ill = 1'b1;
    endcase
  end

  // acc_q/lo_q hold {partial product, multiplier} for MUL and {remainder, dividend} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    step_acc = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    prod     = {acc_q, lo_q};
    if (op_q == OP_MULT && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) prod = -prod;
    fin_lo = prod[WIDTH-1:0];
    fin_hi = prod[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_DIV_EN
    div_rs = {acc_q, lo_q[WIDTH-1]};
    div_ge = div_rs >= {1'b0, mcand_q};
    if (state_q == DIV) begin
      step_acc = div_ge ? (div_rs[WIDTH-1:0] - mcand_q) : div_rs[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], div_ge};
      if (b_q == '0) begin
        fin_lo = '1;
        fin_hi = a_q;
      end else begin
        fin_lo = (op_q == OP_DIV && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -lo_q : lo_q;
        fin_hi = (op_q == OP_DIV && a_q[WIDTH-1]) ? -acc_q : acc_q;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      if (pend_q) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= alu_ill;
        done_q    <= 1'b1;
      end
      if (state_q != IDLE) begin
        if (cnt_q == CW'(WIDTH)) begin
          result_q  <= fin_lo;
          hi_q      <= fin_hi;
          zero_q    <= (fin_lo == '0);
          illegal_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          acc_q <= step_acc;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (accept) begin
        op_q    <= ALUControl;
        a_q     <= A;
        b_q     <= B;
        pend_q  <= !(start_mul || start_div);
        cnt_q   <= '0;
        acc_q   <= '0;
        lo_q    <= start_div ? a_mag : b_mag;
        mcand_q <= start_div ? b_mag : a_mag;
      end
    end
  end

  assign Result  = result_q;
  assign Hi      = hi_q;
  assign Zero    = zero_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Illegal = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): directed corner cases plus random ops against a plain-arithmetic model.
module tb_seq_alu;
  localparam int unsigned W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset, Start, Zero, Busy, Done, Illegal;
  logic [3:0]   ALUControl;
  logic [W-1:0] A, B, Result, Hi;

  seq_alu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Result(Result), .Hi(Hi), .Zero(Zero),
    .Busy(Busy), .Done(Done), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ill;
    int unsigned lat;
    int unsigned start;
    logic [3:0]  op;
  } exp_t;

  exp_t        sbq[$];
  int unsigned total = 0, bad = 0, cyc = 0;
  logic [31:0] hi_model = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    sh = b[4:0];
    e.hi = hi_model; e.lo = '0; e.ill = 1'b0; e.lat = 1; e.op = op; e.start = 0;
    case (op)
      4'd0: e.lo = a + b;
      4'd1: e.lo = a - b;
      4'd2: e.lo = a & b;
      4'd3: e.lo = a | b;
      4'd4: e.lo = ~(a | b);
      4'd5: e.lo = a ^ b;
      4'd6: e.lo = a << sh;
      4'd7: e.lo = a >> sh;
      4'd8: e.lo = (sa < sbv) ? 32'd1 : 32'd0;
      4'd9: e.lo = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin p = sa * sbv; {e.hi, e.lo} = p; e.lat = W + 1; end
      4'd11: begin p = 64'(a) * 64'(b); {e.hi, e.lo} = p; e.lat = W + 1; end
      4'd12, 4'd13: begin
        if (!DIV_EN) e.ill = 1'b1;
        else begin
          e.lat = W + 1;
          if (b == 0) begin e.lo = '1; e.hi = a; end
          else if (op == 4'd12) begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
          else begin e.lo = a / b; e.hi = a % b; end
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.lo == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives Start for one edge, then scrambles the operand inputs so latching is exercised.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; ALUControl = 4'($urandom); A = $urandom; B = $urandom;
    e = model(op, a, b);
    e.start = cyc;
    hi_model = e.hi;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int unsigned budget, input bit chk_busy);
    int unsigned n = 0;
    @(negedge Clk);
    while (!Done && n < budget) begin
      if (chk_busy) chk("busy_high", 64'(Busy), 64'd1);
      n++;
      @(negedge Clk);
    end
    if (!Done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no Done within %0d cycles expected Done", budget);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_zero", 64'(Zero), 64'd1);
    chk("rst_illegal", 64'(Illegal), 64'd0);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Done) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got Done=1 expected Done=0 (no op pending)");
      end else begin
        e = sbq.pop_front();
        chk($sformatf("result(op%0d)", e.op), 64'(Result), 64'(e.lo));
        chk($sformatf("hi(op%0d)", e.op), 64'(Hi), 64'(e.hi));
        chk($sformatf("zero(op%0d)", e.op), 64'(Zero), 64'(e.zero));
        chk($sformatf("illegal(op%0d)", e.op), 64'(Illegal), 64'(e.ill));
        chk($sformatf("latency(op%0d)", e.op), 64'(cyc - e.start), 64'(e.lat));
        chk($sformatf("busy_at_done(op%0d)", e.op), 64'(Busy), 64'd0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    Reset = 1'b1; Start = 1'b0; ALUControl = '0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    chk_reset_state();
    Reset = 1'b0;

    issue(4'd0, 32'h7FFF_FFFF, 32'd1);      wait_done(5, 1'b0);
    issue(4'd1, 32'd5, 32'd5);              wait_done(5, 1'b0);
    issue(4'd10, -32'd3, 32'd7);            wait_done(40, 1'b1);
    issue(4'd11, 32'hFFFF_FFFF, 32'd2);     wait_done(40, 1'b1);
    issue(4'd12, -32'd7, 32'd2);            wait_done(40, DIV_EN);
    issue(4'd13, 32'd7, 32'd0);             wait_done(40, DIV_EN);
    issue(4'd10, 32'h1234, 32'h10);         wait_done(40, 1'b1);
    issue(4'd12, 32'd8, 32'd2);             wait_done(40, DIV_EN);
    issue(4'd15, 32'd1, 32'd2);             wait_done(5, 1'b0);
    issue(4'd14, 32'd0, 32'd0);             wait_done(5, 1'b0);
    issue(4'd6, 32'h1, 32'hFFFF_FFE4);      wait_done(5, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0);      wait_done(5, 1'b0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd0);      wait_done(5, 1'b0);

    // Start raised mid-multiply must be dropped.
    issue(4'd10, 32'd100, 32'd200);
    repeat (4) @(negedge Clk);
    Start = 1'b1; ALUControl = 4'd0; A = 32'd1; B = 32'd2;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(40, 1'b0);
    repeat (3) @(negedge Clk);

    // Reset at cycle 10 of a multiply aborts it.
    issue(4'd11, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    sbq.delete();
    @(negedge Clk);
    chk_reset_state();
    Reset = 1'b0;
    hi_model = '0;
    repeat (40) @(negedge Clk);

    // Reset wins over a simultaneous Start.
    issue(4'd11, 32'd3, 32'd5); wait_done(40, 1'b0);
    Reset = 1'b1; Start = 1'b1; ALUControl = 4'd10; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    chk_reset_state();
    hi_model = '0;
    repeat (40) @(negedge Clk);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      issue(op, a, b);
      wait_done(40, 1'b0);
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
